// File: rtl/ram_arbiter_if.sv
// CPU-side and host-side signal bundle of the program/data RAM arbiter.
// slave = arbiter side, master = CPU/host side.
interface ram_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [15:0]       ctrl_wrd;
  logic [DATA_W-1:0] bus_in;
  logic              cpu_idle;
  logic              cpu_hold;
  logic [DATA_W-1:0] ram_out;
  logic              ram_oe;
  logic              host_req;
  logic              host_valid;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic              cpu_conflict;

  modport slave (
    input  ctrl_wrd, bus_in, cpu_idle,
    input  host_req, host_valid, host_we, host_addr, host_wdata,
    output cpu_hold, ram_out, ram_oe,
    output host_gnt, host_ack, host_rdata, cpu_conflict
  );

  modport master (
    output ctrl_wrd, bus_in, cpu_idle,
    output host_req, host_valid, host_we, host_addr, host_wdata,
    input  cpu_hold, ram_out, ram_oe,
    input  host_gnt, host_ack, host_rdata, cpu_conflict
  );
endinterface

// File: rtl/ram_arbiter.sv
// Program/data RAM + MAR shared between the microcoded CPU and a host loader port.
// Optional fairness limit on host operations per grant: define RAM_ARB_FAIR_EN.
module ram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
`ifdef RAM_ARB_FAIR_EN
  , parameter int HOST_MAX = 8
`endif
) (
  input logic         CLK,
  input logic         RST,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_CPU  = 2'd0,
    S_WAIT = 2'd1,
    S_HOST = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic              hold_q, hold_d;
  logic              gnt_q, gnt_d;
  logic              ack_q, ack_d;
  logic              conflict_q, conflict_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  logic              mi_s, rr_s, rw_s;
  logic              cpu_side_s;
  logic              host_op_s;
  logic              req_ok_s;
  logic              last_op_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic              unused_ctrl_s;

  assign mi_s       = bus.ctrl_wrd[11];
  assign rr_s       = bus.ctrl_wrd[10];
  assign rw_s       = bus.ctrl_wrd[9];
  assign cpu_side_s = (state_q != S_HOST);
  assign host_op_s  = (state_q == S_HOST) && bus.host_req && bus.host_valid;
  assign unused_ctrl_s = ^{bus.ctrl_wrd[15:12], bus.ctrl_wrd[8:0]};

`ifdef RAM_ARB_FAIR_EN
  localparam int CNT_W = $clog2(HOST_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_q, lock_d;
  logic             seen_low_q, seen_low_d;

  assign last_op_s = host_op_s && (cnt_q == CNT_W'(HOST_MAX - 1));
  assign req_ok_s  = bus.host_req && !lock_q;

  // Lockout is released only after one full CPU instruction: idle seen low, then high.
  always_comb begin
    cnt_d      = cnt_q;
    lock_d     = lock_q;
    seen_low_d = seen_low_q;
    if (state_q != S_HOST) begin
      cnt_d = '0;
    end else if (host_op_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    if (last_op_s) begin
      lock_d     = 1'b1;
      seen_low_d = 1'b0;
    end else if (lock_q && !bus.cpu_idle) begin
      seen_low_d = 1'b1;
    end else if (lock_q && seen_low_q) begin
      lock_d     = 1'b0;
      seen_low_d = 1'b0;
    end else begin
      lock_d     = lock_q;
      seen_low_d = seen_low_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      seen_low_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      seen_low_q <= seen_low_d;
    end
  end
`else
  assign last_op_s = 1'b0;
  assign req_ok_s  = bus.host_req;
`endif

  always_comb begin
    state_d    = state_q;
    mar_d      = mar_q;
    rdata_d    = rdata_q;
    conflict_d = conflict_q;
    ack_d      = host_op_s;

    case (state_q)
      S_CPU: begin
        if (req_ok_s) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_CPU;
        end
      end
      S_WAIT: begin
        if (!bus.host_req) begin
          state_d = S_CPU;
        end else if (bus.cpu_idle) begin
          state_d = S_HOST;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOST: begin
        if (!bus.host_req || last_op_s) begin
          state_d = S_CPU;
        end else begin
          state_d = S_HOST;
        end
      end
      default: begin
        state_d = S_CPU;
      end
    endcase

    hold_d = (state_d != S_CPU);
    gnt_d  = (state_d == S_HOST);

    if (cpu_side_s && mi_s) begin
      mar_d = bus.bus_in[ADDR_W-1:0];
    end else begin
      mar_d = mar_q;
    end

    // CPU strobes while the host owns the RAM are dropped and flagged.
    if (!cpu_side_s && (mi_s || rr_s || rw_s)) begin
      conflict_d = 1'b1;
    end else begin
      conflict_d = conflict_q;
    end

    if (host_op_s && !bus.host_we) begin
      rdata_d = mem[bus.host_addr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Single write port; the owning side selects address and data.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = mar_q;
    mem_wdata_s = bus.bus_in;
    if (RST) begin
      mem_we_s = 1'b0;
    end else if (host_op_s) begin
      mem_we_s    = bus.host_we;
      mem_waddr_s = bus.host_addr;
      mem_wdata_s = bus.host_wdata;
    end else if (cpu_side_s && rw_s) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      mem[mem_waddr_s] <= mem_wdata_s;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_CPU;
      mar_q      <= '0;
      hold_q     <= 1'b0;
      gnt_q      <= 1'b0;
      ack_q      <= 1'b0;
      conflict_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      mar_q      <= mar_d;
      hold_q     <= hold_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      conflict_q <= conflict_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.ram_out      = mem[mar_q];
  assign bus.ram_oe       = cpu_side_s && rr_s;
  assign bus.cpu_hold     = hold_q;
  assign bus.host_gnt     = gnt_q;
  assign bus.host_ack     = ack_q;
  assign bus.host_rdata   = rdata_q;
  assign bus.cpu_conflict = conflict_q;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

- Owns the CPU's 2^ADDR_W x DATA_W program/data RAM and its memory address register (MAR).
- Shares the RAM between two requesters:
  - the microcoded CPU, driven by the 16-bit control word;
  - a host loader/debug port, using a req/valid/ack handshake.
- The host gets the RAM only at CPU instruction boundaries, after the arbiter has stalled the CPU's step counter through `cpu_hold`.
- Sits beside the control unit on the shared 8-bit bus.

## Interface
Parameters:
- `ADDR_W`, 4: RAM address width, also the MAR width.
- `DATA_W`, 8: RAM word width, also the bus width.
- `HOST_MAX`, 8: maximum host operations per grant (fair mode only).

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `ctrl_wrd`  in  16  control word. Uses MI = bit 11, RR = bit 10, RW = bit 9.
- `bus_in`  in  DATA_W  CPU bus value.
- `cpu_idle`  in  1  CPU stopped at an instruction boundary (step counter held before T0), or halted.
- `cpu_hold`  out  1  request for the control unit to stop at the next boundary.
- `ram_out`  out  DATA_W  RAM data to the bus.
- `ram_oe`  out  1  drive `ram_out` onto the bus.
- `host_req`  in  1  host wants ownership (level).
- `host_valid`  in  1  host operation present this cycle.
- `host_we`  in  1  1 = write, 0 = read.
- `host_addr`  in  ADDR_W  host address.
- `host_wdata`  in  DATA_W  host write data.
- `host_gnt`  out  1  host owns the RAM.
- `host_ack`  out  1  one-cycle pulse: operation complete.
- `host_rdata`  out  DATA_W  read data; valid while `host_ack` = 1.
- `cpu_conflict`  out  1  sticky error flag.

## Operation
- **States:** CPU (reset state), WAIT, HOST.

**CPU state:**
- MI: `mar <= bus_in[ADDR_W-1:0]`.
- RW: `mem[mar] <= bus_in`.
- RR: `ram_out = mem[mar]` (combinational), `ram_oe = 1`.
- MI and RW in the same word: the write uses the old MAR, then MAR updates.
- If `host_req` = 1 (and the fairness lockout is clear): set `cpu_hold`, go to WAIT.

**WAIT:**
- `cpu_hold` = 1.
- CPU strobes still serviced as in the CPU state.
- `cpu_idle` = 1: go to HOST, `host_gnt` = 1.
- `host_req` drops before the grant: clear `cpu_hold`, go to CPU.

**HOST:**
- Each cycle with `host_valid` = 1 performs one operation.
- Write: `mem[host_addr] <= host_wdata`.
- Read: `host_rdata <= mem[host_addr]`.
- `host_valid` while `host_req` = 0 is ignored.
- `host_req` = 0: go to CPU. Clear `host_gnt` and `cpu_hold` on the same edge.

**Conflict detection:**
- Any of MI, RR or RW while in HOST sets `cpu_conflict`.
- That strobe is ignored and `ram_oe` stays 0.

**Memory:**
- RAM contents are not affected by `RST`.

## Timing
- **Reset values:**
  - state CPU; MAR = 0.
  - `cpu_hold`, `host_gnt`, `host_ack`, `cpu_conflict` = 0.
  - `host_rdata` = 0.
- `cpu_hold` asserts 1 cycle after `host_req` is first sampled high in the CPU state.
- `host_gnt` asserts on the edge after `cpu_idle` is sampled high in WAIT.
- Host operation sampled at edge N:
  - the write commits at edge N;
  - `host_ack` and `host_rdata` are valid during cycle N+1.
- Host throughput: 1 operation per cycle. A read of an address written the previous cycle returns the new data.
- `ram_out` follows MAR with zero latency. A write then a read to the same address in consecutive cycles returns the new data.
- `RST` mid-grant:
  - return to CPU; drop `host_gnt` and `cpu_hold` next cycle;
  - no `host_ack` for an operation sampled on the reset edge.

## Configuration
- `RAM_ARB_FAIR_EN` defined:
  - HOST state counts accepted operations;
  - on the `HOST_MAX`-th operation (acked normally), the arbiter forces a return to CPU;
  - `host_req` is then ignored until `cpu_idle` has been sampled low then high (one full CPU instruction).
- Undefined: no counter, no lockout. The host keeps the RAM as long as `host_req` = 1.

## Test plan
- Reset, then CPU writes `bus_in` = 0x07 with MI, then 0x5A with RW, then RR → `ram_out` = 0x5A, `ram_oe` = 1, `mem[7]` = 0x5A.
- `host_req` = 1 with `cpu_idle` = 0 for 3 cycles, then `cpu_idle` = 1 → `cpu_hold` high 1 cycle after the request; `host_gnt` one edge after idle is sampled.
- Host writes 0x3C to addr 2, then reads addr 2 in the next cycle → acks in consecutive cycles, `host_rdata` = 0x3C.
- MI asserted during HOST → `cpu_conflict` = 1 and stays set; MAR unchanged.
- `RST` during a host read → `host_gnt` = 0 and no ack next cycle; earlier RAM contents preserved.
- With `RAM_ARB_FAIR_EN` and `HOST_MAX` = 8, host streams 10 writes → 8 acks; grant drops; no re-grant until `cpu_idle` toggles low→high.
